// File: rtl/index_counter_bank.sv
// index_counter_bank: N_CH independent index registers with load, strided step,
// and per-channel programmable wrap limits, updated on the falling clock edge.
module index_counter_bank #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned CH_W  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    RESET_INsig,
    input  logic                    DTMBsig,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic                    load,
    input  logic [IDX_W-1:0]        load_value,
    input  logic                    step,
    input  logic [IDX_W-1:0]        stride,
    input  logic                    cfg_we,
    input  logic [IDX_W:0]          cfg_limit,
    output logic [N_CH*IDX_W-1:0]   index_out,
    output logic [IDX_W-1:0]        sel_index,
    output logic [N_CH-1:0]         wrap_pulse,
    output logic                    err
);

    localparam logic [IDX_W:0] LIM_RST = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0] idx_q [N_CH];
    logic [IDX_W-1:0] idx_d [N_CH];
    logic [IDX_W:0]   lim_q [N_CH];
    logic [IDX_W:0]   lim_d [N_CH];
    logic [N_CH-1:0]  wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [IDX_W:0]   sum;

    // Next-state: global clear, unmasked reset, then per-channel load/step/config
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            idx_d[i] = idx_q[i];
            lim_d[i] = lim_q[i];
        end
        wrap_d = '0;
        err_d  = 1'b0;
        sum    = '0;
        if (RESET_INsig) begin
            // Global clear keeps the programmed limits
            for (int i = 0; i < N_CH; i++) idx_d[i] = '0;
        end else if (RESET && !DTMBsig) begin
            for (int i = 0; i < N_CH; i++) begin
                idx_d[i] = '0;
                lim_d[i] = LIM_RST;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_sel == CH_W'(i)) begin
                    // Load and step both judge against the limit held before this edge
                    if (load) begin
                        if ({1'b0, load_value} < lim_q[i]) begin
                            idx_d[i] = load_value;
                        end else begin
                            idx_d[i] = IDX_W'(lim_q[i] - (IDX_W+1)'(1));
                            err_d    = 1'b1;
                        end
                    end else if (step) begin
                        sum = {1'b0, idx_q[i]} + {1'b0, stride};
                        if ({1'b0, stride} >= lim_q[i]) begin
                            err_d = 1'b1;
                        end else if (sum >= lim_q[i]) begin
                            // Single subtraction: an index already above a lowered limit wraps once
                            idx_d[i]  = IDX_W'(sum - lim_q[i]);
                            wrap_d[i] = 1'b1;
                        end else begin
                            idx_d[i] = IDX_W'(sum);
                        end
                    end
                    if (cfg_we) begin
                        if ((cfg_limit == '0) || (cfg_limit > LIM_RST)) begin
                            err_d = 1'b1;
                        end else begin
                            lim_d[i] = cfg_limit;
                        end
                    end
                end
            end
        end
    end

    // State registers, updated on the falling edge
    always_ff @(negedge CLK) begin
        for (int i = 0; i < N_CH; i++) begin
            idx_q[i] <= idx_d[i];
            lim_q[i] <= lim_d[i];
        end
        wrap_q <= wrap_d;
        err_q  <= err_d;
    end

    // Output packing and selected-channel mux of the registered indices
    always_comb begin
        sel_index = '0;
        for (int i = 0; i < N_CH; i++) begin
            index_out[i*IDX_W +: IDX_W] = idx_q[i];
            if (ch_sel == CH_W'(i)) sel_index = idx_q[i];
        end
    end

    assign wrap_pulse = wrap_q;
    assign err        = err_q;

endmodule

// File: tb/tb_index_counter_bank.sv
// Directed self-checking bench for index_counter_bank (default parameters).
module tb_index_counter_bank;

    logic        CLK;
    logic        RESET, RESET_INsig, DTMBsig;
    logic [1:0]  ch_sel;
    logic        load, step, cfg_we;
    logic [7:0]  load_value, stride;
    logic [8:0]  cfg_limit;
    logic [31:0] index_out;
    logic [7:0]  sel_index;
    logic [3:0]  wrap_pulse;
    logic        err;

    int checks = 0;
    int errors = 0;

    index_counter_bank #(.DEPTH(256), .N_CH(4), .IDX_W(8), .CH_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .RESET_INsig(RESET_INsig), .DTMBsig(DTMBsig),
        .ch_sel(ch_sel), .load(load), .load_value(load_value), .step(step),
        .stride(stride), .cfg_we(cfg_we), .cfg_limit(cfg_limit),
        .index_out(index_out), .sel_index(sel_index), .wrap_pulse(wrap_pulse), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One active (falling) edge, then return at the following rising edge to sample
    task automatic cyc();
        @(negedge CLK);
        @(posedge CLK);
    endtask

    task automatic idle();
        RESET = 0; RESET_INsig = 0; DTMBsig = 0;
        load = 0; step = 0; cfg_we = 0;
        load_value = 0; stride = 0; cfg_limit = 0;
    endtask

    task automatic do_load(input logic [1:0] ch, input logic [7:0] v);
        idle(); ch_sel = ch; load = 1; load_value = v; cyc(); idle();
    endtask

    task automatic do_step(input logic [1:0] ch, input logic [7:0] s);
        idle(); ch_sel = ch; step = 1; stride = s; cyc(); idle();
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [8:0] l);
        idle(); ch_sel = ch; cfg_we = 1; cfg_limit = l; cyc(); idle();
    endtask

    task automatic test_reset();
        idle(); ch_sel = 0; RESET = 1; cyc(); cyc(); idle();
        checks++;
        if (index_out !== 32'h0 || wrap_pulse !== 4'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: idx=%h wrap=%b err=%b want 0/0/0", index_out, wrap_pulse, err);
        end
        do_step(0, 1);
        checks++;
        if (sel_index !== 8'd1) begin
            errors++; $display("FAIL reset_step: sel=%0d want 1", sel_index);
        end
    endtask

    task automatic test_wrap();
        do_cfg(1, 9'd10);
        do_load(1, 8'd8);
        checks++;
        if (sel_index !== 8'd8 || err !== 1'b0) begin
            errors++; $display("FAIL wrap_load: sel=%0d err=%b want 8/0", sel_index, err);
        end
        do_step(1, 8'd3);
        checks++;
        if (sel_index !== 8'd1 || wrap_pulse !== 4'b0010) begin
            errors++; $display("FAIL wrap_step: sel=%0d wrap=%b want 1/0010", sel_index, wrap_pulse);
        end
        cyc();
        checks++;
        if (wrap_pulse !== 4'b0000 || index_out[15:8] !== 8'd1) begin
            errors++; $display("FAIL wrap_width: wrap=%b ch1=%0d want 0000/1", wrap_pulse, index_out[15:8]);
        end
    endtask

    task automatic test_holdoff();
        do_load(2, 8'd5);
        idle(); ch_sel = 2; RESET = 1; DTMBsig = 1; cyc(); idle();
        checks++;
        if (index_out !== 32'h0005_0101) begin
            errors++; $display("FAIL holdoff: idx=%h want 00050101", index_out);
        end
        // Global clear also aborts a same-edge load
        idle(); ch_sel = 3; load = 1; load_value = 8'd7; RESET_INsig = 1; cyc(); idle();
        checks++;
        if (index_out !== 32'h0) begin
            errors++; $display("FAIL global_clear: idx=%h want 0", index_out);
        end
        do_load(1, 8'd2);
        do_step(1, 8'd9);
        checks++;
        if (sel_index !== 8'd1 || wrap_pulse !== 4'b0010) begin
            errors++; $display("FAIL lim_kept: sel=%0d wrap=%b want 1/0010", sel_index, wrap_pulse);
        end
    endtask

    task automatic test_default_lim();
        do_load(3, 8'd255);
        checks++;
        if (sel_index !== 8'd255 || err !== 1'b0) begin
            errors++; $display("FAIL max_load: sel=%0d err=%b want 255/0", sel_index, err);
        end
        do_step(3, 8'd1);
        checks++;
        if (sel_index !== 8'd0 || wrap_pulse !== 4'b1000) begin
            errors++; $display("FAIL max_wrap: sel=%0d wrap=%b want 0/1000", sel_index, wrap_pulse);
        end
        idle(); ch_sel = 3; load = 1; load_value = 8'd7; step = 1; stride = 8'd1; cyc(); idle();
        checks++;
        if (sel_index !== 8'd7 || wrap_pulse !== 4'b0000) begin
            errors++; $display("FAIL load_over_step: sel=%0d wrap=%b want 7/0000", sel_index, wrap_pulse);
        end
    endtask

    task automatic test_illegal();
        do_cfg(0, 9'd0);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL cfg_zero: err=%b want 1", err);
        end
        do_load(0, 8'd200);
        checks++;
        if (sel_index !== 8'd200 || err !== 1'b0) begin
            errors++; $display("FAIL lim_unchanged: sel=%0d err=%b want 200/0", sel_index, err);
        end
        do_cfg(0, 9'd4);
        checks++;
        if (sel_index !== 8'd200 || err !== 1'b0) begin
            errors++; $display("FAIL cfg_no_touch: sel=%0d err=%b want 200/0", sel_index, err);
        end
        do_step(0, 8'd1);
        checks++;
        if (sel_index !== 8'd197 || wrap_pulse !== 4'b0001) begin
            errors++; $display("FAIL over_lim_wrap: sel=%0d wrap=%b want 197/0001", sel_index, wrap_pulse);
        end
        do_load(0, 8'd6);
        checks++;
        if (sel_index !== 8'd3 || err !== 1'b1) begin
            errors++; $display("FAIL load_clamp: sel=%0d err=%b want 3/1", sel_index, err);
        end
        do_step(0, 8'd4);
        checks++;
        if (sel_index !== 8'd3 || err !== 1'b1 || wrap_pulse !== 4'b0000) begin
            errors++; $display("FAIL big_stride: sel=%0d err=%b wrap=%b want 3/1/0000", sel_index, err, wrap_pulse);
        end
        do_step(0, 8'd0);
        checks++;
        if (sel_index !== 8'd3 || err !== 1'b0 || wrap_pulse !== 4'b0000) begin
            errors++; $display("FAIL zero_stride: sel=%0d err=%b wrap=%b want 3/0/0000", sel_index, err, wrap_pulse);
        end
        do_cfg(0, 9'd257);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL cfg_over: err=%b want 1", err);
        end
        do_step(0, 8'd2);
        checks++;
        if (sel_index !== 8'd1 || wrap_pulse !== 4'b0001) begin
            errors++; $display("FAIL lim4_kept: sel=%0d wrap=%b want 1/0001", sel_index, wrap_pulse);
        end
        do_cfg(0, 9'd256);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL cfg_max: err=%b want 0", err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_idx [5] = '{8'd2, 8'd4, 8'd1, 8'd3, 8'd0};
        logic       exp_wr  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_cfg(2, 9'd5);
        do_load(2, 8'd0);
        idle(); ch_sel = 2; step = 1; stride = 8'd2;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (sel_index !== exp_idx[k] || wrap_pulse[2] !== exp_wr[k]) begin
                errors++;
                $display("FAIL b2b_%0d: sel=%0d wrap2=%b want %0d/%b", k, sel_index, wrap_pulse[2], exp_idx[k], exp_wr[k]);
            end
        end
        idle();
    endtask

    task automatic test_reset_lim();
        do_cfg(0, 9'd4);
        idle(); ch_sel = 0; RESET = 1; cfg_we = 1; cfg_limit = 9'd2; cyc(); idle();
        checks++;
        if (index_out !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_abort: idx=%h err=%b want 0/0", index_out, err);
        end
        do_load(0, 8'd6);
        checks++;
        if (sel_index !== 8'd6 || err !== 1'b0) begin
            errors++; $display("FAIL reset_lim: sel=%0d err=%b want 6/0", sel_index, err);
        end
    endtask

    initial begin
        idle(); ch_sel = 0;
        test_reset();
        test_wrap();
        test_holdoff();
        test_default_lim();
        test_illegal();
        test_back_to_back();
        test_reset_lim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
